// File: rtl/approx_adder_sweep_ctrl.sv
// approx_adder_sweep_ctrl
//   Drives an exhaustive operand sweep into one approximate adder and
//   accumulates error statistics against the exact sum.
//
// Parameters
//   IN_W     operand width; adder has 2*IN_W inputs and IN_W+1 outputs
//   ET       error threshold; a run violates it when max_err > ET
//   DUT_LAT  adder latency in cycles, 0..7 (0 = combinational)
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         begin a run (sampled in IDLE only)
//   abort         stop the current run (sampled in RUN only)
//   dut_in        adder input vector, a = low IN_W bits, b = high IN_W bits
//   approx_sum    adder outputs, LSB first
//   busy          run in progress
//   done          one-cycle pulse at run completion
//   max_err       largest |approx - exact| seen in the run
//   err_count     number of vectors with nonzero error
//   sum_err       total |approx - exact| over the run
//   et_violation  max_err > ET, sticky within a run

// Absolute error of one adder result against the exact sum.
module approx_adder_sweep_err #(
   parameter int IN_W = 2
) (
   input  logic [IN_W-1:0] a,
   input  logic [IN_W-1:0] b,
   input  logic [IN_W:0]   approx,
   output logic [IN_W:0]   err
);
   logic [IN_W:0] exact;

   always_comb begin
      exact = {1'b0, a} + {1'b0, b};
      // Unsigned difference taken in whichever direction stays non-negative.
      if (approx >= exact) err = approx - exact;
      else                 err = exact - approx;
   end
endmodule

module approx_adder_sweep_ctrl #(
   parameter int IN_W    = 2,
   parameter int ET      = 7,
   parameter int DUT_LAT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [2*IN_W-1:0] dut_in,
   input  logic [IN_W:0]     approx_sum,
   output logic              busy,
   output logic              done,
   output logic [IN_W:0]     max_err,
   output logic [2*IN_W:0]   err_count,
   output logic [3*IN_W:0]   sum_err,
   output logic              et_violation
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0]        LAT      = 3'(DUT_LAT);
   localparam logic [31:0]       ET_U     = 32'(ET);
   localparam logic [2*IN_W-1:0] LAST_VEC = '1;

   logic [1:0]    state;
   logic [2:0]    hold_cnt;
   logic [IN_W:0] err;
   logic [IN_W:0] new_max;
   logic          err_nz;
   logic          new_viol;

   approx_adder_sweep_err #(.IN_W(IN_W)) u_err (
      .a      (dut_in[IN_W-1:0]),
      .b      (dut_in[2*IN_W-1:IN_W]),
      .approx (approx_sum),
      .err    (err)
   );

   // Candidate statistics for the current vector; only committed on the
   // last edge of its hold window.
   always_comb begin
      err_nz   = |err;
      new_max  = (err > max_err) ? err : max_err;
      new_viol = 32'(new_max) > ET_U;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         hold_cnt     <= '0;
         dut_in       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         max_err      <= '0;
         err_count    <= '0;
         sum_err      <= '0;
         et_violation <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state        <= S_RUN;
                  busy         <= 1'b1;
                  hold_cnt     <= '0;
                  dut_in       <= '0;
                  max_err      <= '0;
                  err_count    <= '0;
                  sum_err      <= '0;
                  et_violation <= 1'b0;
               end
            end
            S_RUN: begin
               if (abort) begin
                  // Partial results are kept; no sample on this edge.
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (hold_cnt == LAT) begin
                  // Last edge of the hold window: adder output has settled
                  // for this vector.
                  hold_cnt     <= '0;
                  max_err      <= new_max;
                  err_count    <= err_count + {{(2*IN_W){1'b0}}, err_nz};
                  sum_err      <= sum_err + {{(2*IN_W){1'b0}}, err};
                  et_violation <= et_violation | new_viol;
                  dut_in       <= dut_in + 1'b1; // wraps to 0 after LAST_VEC
                  if (dut_in == LAST_VEC) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 3'd1;
               end
            end
            S_DONE: begin
               // start is not looked at here, so a held start is taken on
               // the next IDLE cycle.
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule
